// File: rtl/axi4_burst_master.sv
// AXI4 initiator: turns single-word commands into one INCR burst at a time (AW/W/B or AR/R).
// Optional response watchdog is enabled by defining AXI4_MASTER_TIMEOUT_EN.
module axi4_burst_master #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      done,
  output logic [1:0]                done_resp,
  output logic                      done_err,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [7:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic [1:0]                AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY
);
  localparam int unsigned BYTES   = DATA_WIDTH / 8;
  localparam int unsigned SIZE_W  = $clog2(BYTES);
  localparam int unsigned SPAN_W  = 20;
  localparam logic [1:0]  SLVERR  = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q, cmd_addr_al;
  logic [7:0]            len_q;
  logic [8:0]            loaded;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BYTES-1:0]      wstrb_q;
  logic                  wvalid_q, wlast_q;
  logic [1:0]            resp_q;
  logic                  err_q;
  logic [SPAN_W-1:0]     span;
  logic                  crosses, accept, load, w_hs, b_hs, r_hs, timeout;

  // Burst end address relative to its 4KB page, computed on the aligned start address.
  assign cmd_addr_al = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign span        = SPAN_W'(cmd_addr_al[11:0]) + (SPAN_W'(cmd_len) + SPAN_W'(1)) * SPAN_W'(BYTES);
  assign crosses     = span > SPAN_W'(4096);

  assign accept = (state == IDLE) && cmd_valid;
  assign load   = wr_valid && wr_ready;
  assign w_hs   = wvalid_q && WREADY;
  assign b_hs   = (state == WR_RESP) && BVALID;
  assign r_hs   = (state == RD_DATA) && RVALID && rd_ready;

`ifdef AXI4_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             waiting;

  assign waiting = (state == WR_RESP) || (state == RD_DATA);
  assign timeout = waiting && !b_hs && !r_hs && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on every response handshake and outside the wait states.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                  tmo_cnt <= '0;
    else if (waiting && !b_hs && !r_hs) tmo_cnt <= tmo_cnt + TMO_W'(1);
    else                           tmo_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    AWVALID   = 1'b0;
    ARVALID   = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = crosses ? DONE : (cmd_write ? WR_ADDR : RD_ADDR);
      end
      WR_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        wr_ready = (!wvalid_q || WREADY) && (loaded <= {1'b0, len_q});
        if (w_hs && wlast_q) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        BREADY = 1'b1;
        if (BVALID || timeout) state_nxt = DONE;
      end
      RD_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rd_valid = RVALID;
        rd_data  = RDATA;
        rd_last  = RLAST;
        RREADY   = rd_ready;
        if ((r_hs && RLAST) || timeout) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, one-entry W stage and burst status.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q   <= '0;
      len_q    <= '0;
      loaded   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
      resp_q   <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= cmd_addr_al;
        len_q  <= cmd_len;
        loaded <= '0;
        resp_q <= crosses ? SLVERR : 2'b00;
        err_q  <= crosses;
      end
      if (load) begin
        wdata_q  <= wr_data;
        wstrb_q  <= '1;
        wvalid_q <= 1'b1;
        wlast_q  <= (loaded == {1'b0, len_q});
        loaded   <= loaded + 9'd1;
      end else if (w_hs) begin
        wvalid_q <= 1'b0;
      end
      if (b_hs) resp_q <= BRESP;
      if (r_hs && (RRESP != 2'b00)) resp_q <= SLVERR;
      if (timeout) begin
        resp_q <= SLVERR;
        err_q  <= 1'b1;
      end
    end
  end

  assign AWADDR    = addr_q;
  assign AWLEN     = len_q;
  assign AWSIZE    = 3'(SIZE_W);
  assign AWBURST   = 2'b01;
  assign ARADDR    = addr_q;
  assign ARLEN     = len_q;
  assign ARSIZE    = 3'(SIZE_W);
  assign ARBURST   = 2'b01;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WLAST     = wlast_q;
  assign WVALID    = wvalid_q;
  assign done_resp = resp_q;
  assign done_err  = err_q;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Self-checking bench for axi4_burst_master: directed vector table, reset corner case and
// randomized bursts, with a bench-side slave and a page/response reference model.
module tb_axi4_burst_master;
  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 32;
  localparam int          TMO = 16;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_valid, wr_ready, rd_last, rd_valid, rd_ready;
  logic          done, done_err;
  logic [1:0]    done_resp;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [7:0]    AWLEN, ARLEN;
  logic [2:0]    AWSIZE, ARSIZE;
  logic [1:0]    AWBURST, ARBURST, BRESP, RRESP;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0]    WSTRB;

  always #5 ACLK = ~ACLK;

  axi4_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [31:0] base;
    int          aw_dly;
    int          mode;      // 0 always ready, 1 periodic stalls/gaps, 2 random
    logic [1:0]  bresp;
    int          err_beat;  // read beat index carrying SLVERR
    bit          b_never;
    logic [1:0]  exp_resp;
    bit          exp_err;
    bit          reject;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: page-crossing rule on the aligned address and worst-response rule.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   span;
    span     = int'(v.addr[11:0] & 12'hFFC) + (int'(v.len) + 1) * 4;
    r.reject = (span > 4096);
    r.exp_err = r.reject || (v.wr && v.b_never);
    if (r.exp_err)  r.exp_resp = 2'b10;
    else if (v.wr)  r.exp_resp = v.bresp;
    else            r.exp_resp = (v.err_beat <= int'(v.len)) ? 2'b10 : 2'b00;
    return r;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BRESP = 2'b00; BVALID = 0;
    ARREADY = 0; RDATA = '0; RRESP = 2'b00; RLAST = 0; RVALID = 0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  wi = 0, wseen = 0, rsent = 0, rseen = 0, awv_cnt = 0, arv_cnt = 0, last_hs = -1;
    bit  aw_done = 0, ar_done = 0, w_done = 0, b_sent = 0, r_fin = 0, finished = 0;
    bit  ok_order = 1, ok_stable = 1, ok_mirror = 1, ok_idle = 1;
    logic        p_wstall = 0, p_awstall = 0, p_arstall = 0, p_wlast = 0;
    logic [31:0] p_wdata = '0;
    logic [15:0] p_awaddr = '0, p_araddr = '0;
    logic [15:0] exp_addr;
    exp_addr = v.addr & 16'hFFFC;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge ACLK);
      cmd_valid = (cyc == 0);
      cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
      AWREADY  = (awv_cnt >= v.aw_dly);
      ARREADY  = (arv_cnt >= v.aw_dly);
      WREADY   = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      wr_valid = v.wr && (cyc > 0) && (wi <= int'(v.len)) && (v.mode != 2 || $urandom_range(0, 1) == 1);
      wr_data  = v.base + 32'(wi);
      BVALID   = w_done && !b_sent && !v.b_never && (v.mode != 2 || $urandom_range(0, 1) == 1);
      BRESP    = v.bresp;
      RVALID   = !v.wr && ar_done && (rsent <= int'(v.len)) &&
                 ((v.mode == 0) || (v.mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1)));
      RDATA    = v.base + 32'(rsent);
      RLAST    = (rsent == int'(v.len));
      RRESP    = (rsent == v.err_beat) ? 2'b10 : 2'b00;
      rd_ready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? (cyc % 3 != 0) : 1'($urandom_range(0, 1));
      #1;
      if (cyc == 0) check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
      if (cyc == 1 && !v.reject) check({tag, " axvalid_latency"}, 64'(v.wr ? AWVALID : ARVALID), 64'd1);
      if (v.reject && (AWVALID || ARVALID)) ok_idle = 0;
      if (!v.wr && (AWVALID || WVALID || BREADY)) ok_idle = 0;
      if (v.wr && (ARVALID || RREADY || rd_valid)) ok_idle = 0;
      if (p_awstall && !(AWVALID && AWADDR == p_awaddr)) ok_stable = 0;
      if (p_arstall && !(ARVALID && ARADDR == p_araddr)) ok_stable = 0;
      if (p_wstall && !(WVALID && WDATA == p_wdata && WLAST == p_wlast)) ok_stable = 0;
      if (!aw_done && (WVALID || (wr_valid && wr_ready))) ok_order = 0;
      if (ar_done && !r_fin) begin
        if (RREADY !== rd_ready || rd_valid !== RVALID) ok_mirror = 0;
      end else if (RREADY || rd_valid) ok_mirror = 0;
      if (AWVALID && AWREADY) begin
        check({tag, " aw_fields"}, 64'({AWADDR, AWLEN, AWSIZE, AWBURST}), 64'({exp_addr, v.len, 3'd2, 2'b01}));
        aw_done = 1;
      end
      if (ARVALID && ARREADY) begin
        check({tag, " ar_fields"}, 64'({ARADDR, ARLEN, ARSIZE, ARBURST}), 64'({exp_addr, v.len, 3'd2, 2'b01}));
        ar_done = 1;
      end
      if (WVALID && WREADY) begin
        check({tag, " wdata"}, 64'(WDATA), 64'(v.base + 32'(wseen)));
        check({tag, " wlast_wstrb"}, 64'({WLAST, WSTRB}), 64'({1'(wseen == int'(v.len)), 4'hF}));
        if (wseen == int'(v.len)) begin
          w_done = 1;
          if (v.b_never) last_hs = cyc + TMO;
        end
        wseen++;
      end
      if (wr_valid && wr_ready) wi++;
      if (BVALID && BREADY) begin b_sent = 1; last_hs = cyc; end
      if (rd_valid && rd_ready) begin
        check({tag, " rdata"}, 64'({rd_last, rd_data}), 64'({1'(rseen == int'(v.len)), 32'(v.base + 32'(rseen))}));
        if (rseen == int'(v.len)) begin r_fin = 1; last_hs = cyc; end
        rseen++;
      end
      if (RVALID && RREADY) rsent++;
      if (AWVALID) awv_cnt++;
      if (ARVALID) arv_cnt++;
      if (done) begin
        check({tag, " done_cycle"}, 64'(cyc), 64'(v.reject ? 1 : last_hs + 1));
        check({tag, " done_resp_err"}, 64'({done_resp, done_err}), 64'({v.exp_resp, v.exp_err}));
        finished = 1;
      end
      p_awstall = AWVALID && !AWREADY; p_awaddr = AWADDR;
      p_arstall = ARVALID && !ARREADY; p_araddr = ARADDR;
      p_wstall  = WVALID && !WREADY;   p_wdata = WDATA; p_wlast = WLAST;
    end
    if (!finished) check({tag, " burst_timeout"}, 64'd0, 64'd1);
    @(negedge ACLK);
    idle_inputs();
    #1;
    check({tag, " done_pulse_cmd_ready"}, 64'({done, cmd_ready}), 64'b01);
    check({tag, " w_after_aw"}, 64'(ok_order), 64'd1);
    check({tag, " stall_stable"}, 64'(ok_stable), 64'd1);
    check({tag, " r_mirror"}, 64'(ok_mirror), 64'd1);
    check({tag, " idle_channels"}, 64'(ok_idle), 64'd1);
    if (!v.reject) check({tag, " beats"}, 64'(v.wr ? wseen : rseen), 64'(int'(v.len) + 1));
  endtask

  task automatic reset_mid_burst();
    bit quiet = 1;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0040; cmd_len = 8'd7;
    AWREADY = 1; WREADY = 0; wr_valid = 1; wr_data = 32'h55;
    @(negedge ACLK);
    cmd_valid = 0;
    repeat (3) @(negedge ACLK);
    #1 check("rst_mid pre_wvalid", 64'(WVALID), 64'd1);
    #1 ARESETn = 0;
    #1 check("rst_mid valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY, rd_valid, done, wr_ready}), 64'd0);
    check("rst_mid wdata", 64'(WDATA), 64'd0);
    idle_inputs();
    @(negedge ACLK);
    ARESETn = 1;
    @(posedge ACLK);
    #1 check("rst_mid cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (4) begin
      @(negedge ACLK);
      if (AWVALID || WVALID || ARVALID || done) quiet = 0;
    end
    check("rst_mid quiet", 64'(quiet), 64'd1);
  endtask

  vec_t tbl[11];

  initial begin
    //            wr  addr      len     base          dly mode bresp  err  bn  resp   err rej
    tbl[0]  = '{1'b1, 16'h0010, 8'd3,   32'h000000A0, 0,  0,   2'b00, 99,  1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0100, 8'd7,   32'h00001000, 0,  1,   2'b00, 99,  1'b0, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h0200, 8'd5,   32'h000000B0, 5,  1,   2'b00, 99,  1'b0, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 16'h0300, 8'd3,   32'h00002000, 0,  0,   2'b00, 2,   1'b0, 2'b10, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'h0400, 8'd1,   32'h000000C0, 1,  0,   2'b10, 99,  1'b0, 2'b10, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h0FF8, 8'd3,   32'h000000F0, 0,  0,   2'b00, 99,  1'b0, 2'b10, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 16'h0FFC, 8'd0,   32'h00003000, 0,  0,   2'b00, 99,  1'b0, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 16'h1F00, 8'd64,  32'h00004000, 0,  0,   2'b00, 99,  1'b0, 2'b10, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 16'h0003, 8'd0,   32'h000000D0, 0,  0,   2'b00, 99,  1'b0, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 16'h2F00, 8'd63,  32'h00005000, 2,  2,   2'b00, 99,  1'b0, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'h5000, 8'd255, 32'h0000E000, 3,  2,   2'b00, 99,  1'b0, 2'b00, 1'b0, 1'b0};

    idle_inputs();
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1;
    @(posedge ACLK);
    #1;
    check("reset cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset valids", 64'({AWVALID, ARVALID, WVALID, BREADY, RREADY, rd_valid, done, done_err}), 64'd0);
    check("reset done_resp", 64'(done_resp), 64'd0);
    check("reset addr_data", 64'({AWADDR, ARADDR, WDATA}), 64'd0);
    check("reset wstrb_wlast", 64'({WSTRB, WLAST}), 64'd0);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    reset_mid_burst();

`ifdef AXI4_MASTER_TIMEOUT_EN
    begin
      vec_t t = '{1'b1, 16'h0600, 8'd2, 32'h00000060, 0, 0, 2'b00, 99, 1'b1, 2'b10, 1'b1, 1'b0};
      run_vec(t, "timeout_b");
    end
`endif

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = 16'($urandom) & 16'hFFFC;
      if ($urandom_range(0, 2) == 0) v.addr[11:8] = 4'hF;
      v.len    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      v.base   = $urandom;
      v.aw_dly = $urandom_range(0, 3);
      v.mode   = $urandom_range(0, 2);
      v.bresp  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      v.err_beat = ($urandom_range(0, 2) == 0) ? $urandom_range(0, int'(v.len)) : 999;
      v.b_never  = 1'b0;
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_burst_master.md
# axi4_burst_master

AXI4 initiator that turns single-word commands into INCR bursts on the AXI4 interface of the `axi4` slave. It issues AW, then W, then collects B for writes, and issues AR then collects R for reads. It is the stimulus-side counterpart used in front of the slave, and its bus behaviour must satisfy the slave-side handshake and ordering checks.

## Interface
- ADDR_WIDTH, 16, AxADDR and cmd_addr width
- DATA_WIDTH, 32, WDATA/RDATA width; BYTES = DATA_WIDTH/8, AxSIZE = log2(BYTES)
- TIMEOUT_CYCLES, 256, response watchdog limit (only with AXI4_MASTER_TIMEOUT_EN)
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in/out  1  command handshake; cmd_ready = 1 only in IDLE
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start byte address; low log2(BYTES) bits forced to 0
- cmd_len  in  8  beats − 1 (AxLEN)
- wr_data  in  DATA_WIDTH  write beat data
- wr_valid / wr_ready  in/out  1  write data stream handshake
- rd_data  out  DATA_WIDTH  read beat data (RDATA)
- rd_last  out  1  RLAST passthrough
- rd_valid / rd_ready  out/in  1  read data stream handshake
- done  out  1  one-cycle completion pulse
- done_resp  out  2  worst response of the burst (00 OKAY, 10 SLVERR)
- done_err  out  1  burst aborted (4KB crossing or timeout)
- AWADDR, AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWVALID  out; AWREADY  in
- WDATA, WSTRB[BYTES-1:0], WLAST, WVALID  out; WREADY  in
- BRESP[1:0], BVALID  in; BREADY  out
- ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID  out; ARREADY  in
- RDATA, RRESP[1:0], RLAST, RVALID  in; RREADY  out

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: on cmd_valid, latch the command. If cmd_addr[11:0] + (cmd_len+1)*BYTES > 4096, go to DONE with done_err=1, done_resp=10, and no bus activity. Otherwise go to WR_ADDR or RD_ADDR.
- WR_ADDR/RD_ADDR: AxVALID=1 with AxBURST=01 and AxSIZE fixed. Hold AxVALID and AxADDR/AxLEN stable until AxREADY. On the handshake, go to WR_DATA or RD_DATA.
- WR_DATA: registered one-entry W stage.
  - wr_ready = (!WVALID || WREADY) && loaded < cmd_len+1.
  - Each wr_valid&&wr_ready loads WDATA, sets WVALID=1, WSTRB all ones, WLAST = (loaded == cmd_len).
  - WVALID and payload stay stable until WREADY.
  - After the WLAST handshake, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, done_resp=BRESP, then go to DONE.
- RD_DATA: rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST, RREADY=rd_ready (all 0 outside RD_DATA).
  - done_resp accumulates as sticky SLVERR if any beat has RRESP=10.
  - After the RVALID&&RREADY&&RLAST handshake, go to DONE.
  - RLAST arriving before the expected beat count also ends the burst. The beat count is not checked.
- DONE: done=1 for one cycle, then IDLE. done_resp and done_err hold until the next accepted command.
- No outstanding overlap: one burst at a time; AW always precedes all W beats.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, all AxVALID/WVALID/BREADY/RREADY/rd_valid/done/done_err = 0, done_resp = 00, all data/addr outputs = 0, cmd_ready = 1 from the first cycle after release.
- Reset mid-burst aborts immediately. There is no done pulse and no further bus activity.
- Command accepted at edge N: AxVALID=1 in cycle N+1.
- AW handshake at edge M: wr_ready may be 1 in cycle M+1. WVALID first rises in the cycle after the first wr handshake.
- Sustained throughput is 1 W beat per cycle when WREADY=1 and wr_valid=1.
- Last handshake (B, or final R beat) at edge K: done=1 in cycle K+1, cmd_ready=1 in cycle K+2.
- A 4KB reject is accepted at edge N, gives done=1 in cycle N+1, and cmd_ready=1 in cycle N+2.

## Configuration
- AXI4_MASTER_TIMEOUT_EN defined:
  - A counter runs in WR_RESP and RD_DATA. It resets on every B/R handshake.
  - On reaching TIMEOUT_CYCLES it drops BREADY/RREADY, goes to DONE with done_err=1 and done_resp=10.
- AXI4_MASTER_TIMEOUT_EN undefined: no counter; the block waits indefinitely for B/R.

## Test plan
- Write burst, addr 0x0010, len 3, data 0xA0..0xA3, slave always ready: AW then 4 W beats with WLAST on 0xA3 only, BRESP=00. Expect done one cycle after B, done_resp=00, done_err=0.
- Read burst, addr 0x0100, len 7, slave inserts RVALID gaps and bench toggles rd_ready: 8 beats forwarded in order. RREADY mirrors rd_ready. done follows the RLAST handshake.
- AWREADY held low 5 cycles, WREADY stalls every other cycle: AWVALID, WVALID, WDATA and WLAST remain stable while stalled, and no W beat precedes the AW handshake.
- Read with RRESP=10 on beat 2 of 4: done_resp=10, done_err=0. Write with BRESP=10: done_resp=10.
- Command addr 0x0FF8, len 3 (16 B crosses 4KB): no AxVALID ever asserted; done and done_err=1 on the next cycle; done_resp=10.
- With AXI4_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, BVALID never asserted: done_err=1 exactly 16 cycles into WR_RESP. Separately, ARESETn low mid-W-burst: all VALIDs 0 immediately and cmd_ready=1 after release.
